iterative_shifter_unit: RTL and testbench
=========================================

// Module: iterative_shifter_unit
// PURPOSE
// Multi-cycle, parametrised successor to the combinational operand shifter.
// Computes ARM data-processing shifter operand and carry-out for LSL/LSR/ASR/ROR/RRX.
// Shifts STEP bits per clock and uses a start/busy/done handshake.
// Sits between register-file read and the ALU; the control unit stalls on busy.
// PARAMETERS
// WIDTH  32  operand/result width; power of 2, >=8
// STEP   4   max bits shifted per clock; power of 2, 1..WIDTH
// AMT_W  8   shift-amount width (ARM uses Rs[7:0])
// PORTS
// clk        in   1      single clock; all state changes on rising edge
// reset      in   1      asynchronous, active-high
// start      in   1      request; sampled only when state is IDLE or DONE
// op         in   3      0 LSL, 1 LSR, 2 ASR, 3 ROR, 4 RRX; 5-7 reserved (treated as LSL #0)
// operand_in in   WIDTH  value to shift (Rm)
// amount     in   AMT_W  shift amount (immediate or Rs[7:0]; unsigned)
// cin        in   1      current C flag
// busy       out  1      high while state is RUN
// done       out  1      one-cycle pulse: result/cout valid
// result     out  WIDTH  shifter operand; held until the next accepted start
// cout       out  1      shifter carry-out; held with result
// BEHAVIOUR
// - Reset: state IDLE; busy=0, done=0, result=0, cout=0.
//   Reset asserted mid-operation aborts immediately; no partial result is kept.
// - FSM states: IDLE, RUN, DONE.
//   IDLE -start-> RUN.  RUN -(remaining==0)-> DONE.
//   DONE -start-> RUN;  DONE -!start-> IDLE.
// - Accept (edge E0): latch op, operand, cin, and remaining=N.
//   result:=operand_in, cout:=cin. No shift is applied at E0.
// - N (effective count):
//   LSL/LSR/ASR: min(amount, WIDTH+1).
//   ROR: amount mod WIDTH; if amount!=0 and amount mod WIDTH==0, N=0 with a special case.
//   RRX: 1. Reserved op: 0.
// - RUN: each edge shifts by k=min(STEP, remaining) and does remaining-=k.
//   cout = last bit shifted out. Fill bits: LSL/LSR 0; ASR sign bit; ROR wrap.
//   RRX: result={cin, op[WIDTH-1:1]}, cout=op[0].
//   Result is kept in a WIDTH-bit register plus the cout bit, so N=WIDTH+1 yields:
//   LSL/LSR -> 0, cout 0; ASR -> all sign, cout=sign.
// - ROR special case (amount nonzero multiple of WIDTH): result=operand, cout=operand[WIDTH-1].
// - N==0 (excluding the ROR special case): result=operand, cout=cin.
// - Latency: done high in the cycle after edge E0+max(1, ceil(N/STEP)).
//   busy is high from E0 up to that edge.
// - start while RUN: ignored; no queueing.
//   start in the DONE cycle: accepted (back-to-back, no bubble).
// - operand_in, amount and cin are don't-care except at accept.
// STRUCTURE
// - Package shifter_pkg holds the op encodings (SH_LSL..SH_RRX) and FSM state localparams.
//   These are shared with the decoder/control unit.
// - One sub-module, shift_step: combinational single step.
//   Inputs: value, carry, op, k (0..STEP). Outputs: {value, carry}.
// - Top level holds the FSM, remaining counter, and N computation.
// TESTING (WIDTH=32, STEP=4)
// 1. LSL, operand 35, amount 3, cin 0 -> result 280, cout 0; done after E0+1.
// 2. LSR, operand 0x80000001, amount 32 -> result 0, cout 1; done after E0+8, busy for 8 cycles.
// 3. ASR, operand 0x80000000, amount 40 (N=33) -> result 0xFFFFFFFF, cout 1; done after E0+9.
// 4. ROR 0x000000F0 #36 -> 0x0000000F, cout 0.
//    ROR 0x80000000 #32 -> 0x80000000, cout 1.
// 5. RRX, operand 0x00000003, cin 1 -> result 0x80000001, cout 1; done after E0+1.
//    LSL #0, cin 1 -> result unchanged, cout 1.
// 6. LSL #20 with start re-pulsed during RUN -> ignored.
//    New start in the DONE cycle is accepted.
//    reset at E0+3 of a new run -> busy/done/result/cout all 0 immediately.

Source files
------------

// File: rtl/shifter_pkg.sv
// Op encodings and FSM states for the iterative shifter.
// Shared with the decoder and control unit.
package shifter_pkg;

  localparam logic [2:0] SH_LSL = 3'd0;
  localparam logic [2:0] SH_LSR = 3'd1;
  localparam logic [2:0] SH_ASR = 3'd2;
  localparam logic [2:0] SH_ROR = 3'd3;
  localparam logic [2:0] SH_RRX = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/shift_step.sv
// One combinational shifter step of k (0..STEP) single-bit shifts.
// Ports: value/carry in, op, k; nvalue/ncarry out.
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  parameter int KW    = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] value,
  input  logic             carry,
  input  logic [2:0]       op,
  input  logic [KW-1:0]    k,
  output logic [WIDTH-1:0] nvalue,
  output logic             ncarry
);

  logic [WIDTH-1:0] v;
  logic             c;

  always_comb begin
    v = value;
    c = carry;
    for (int i = 0; i < STEP; i++) begin
      if (KW'(i) < k) begin
        case (op)
          SH_LSL: begin
            c = v[WIDTH-1];
            v = {v[WIDTH-2:0], 1'b0};
          end
          SH_LSR: begin
            c = v[0];
            v = {1'b0, v[WIDTH-1:1]};
          end
          SH_ASR: begin
            c = v[0];
            v = {v[WIDTH-1], v[WIDTH-1:1]};
          end
          SH_ROR: begin
            c = v[0];
            v = {c, v[WIDTH-1:1]};
          end
          // rotate right through carry
          SH_RRX: {v, c} = {c, v};
          default: ;
        endcase
      end
    end
    nvalue = v;
    ncarry = c;
  end

endmodule

// File: rtl/iterative_shifter_unit.sv
// Multi-cycle ARM shifter operand/carry unit, STEP bits per clock.
// Ports: start/op/operand_in/amount/cin in; busy/done/result/cout out.
module iterative_shifter_unit
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  parameter int AMT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand_in,
  input  logic [AMT_W-1:0] amount,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
);

  localparam int RW = $clog2(WIDTH + 2);
  localparam int LW = $clog2(WIDTH);
  localparam int KW = $clog2(STEP + 1);

  state_e           state;
  state_e           nstate;
  logic [2:0]       op_q;
  logic [RW-1:0]    rem;
  logic [RW-1:0]    n;
  logic [KW-1:0]    k;
  logic             accept;
  logic             ror_wrap;
  logic [WIDTH-1:0] sv;
  logic             sc;

  assign accept = start && (state != ST_RUN);
  assign busy   = (state == ST_RUN);
  assign done   = (state == ST_DONE);

  // Effective count; WIDTH+1 is enough to flush value and carry.
  always_comb begin
    n        = '0;
    ror_wrap = 1'b0;
    unique case (1'b1)
      (op == SH_LSL),
      (op == SH_LSR),
      (op == SH_ASR): begin
        if (32'(amount) > WIDTH + 1)
          n = RW'(WIDTH + 1);
        else
          n = RW'(amount);
      end
      (op == SH_ROR): begin
        n = RW'(amount[LW-1:0]);
        ror_wrap = (amount != '0) &&
                   (amount[LW-1:0] == '0);
      end
      (op == SH_RRX): n = RW'(1);
      default: ;
    endcase
  end

  assign k = (rem > RW'(STEP)) ? KW'(STEP)
                               : KW'(rem);

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .KW    (KW)
  ) u_step (
    .value  (result),
    .carry  (cout),
    .op     (op_q),
    .k      (k),
    .nvalue (sv),
    .ncarry (sc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= nstate;
  end

  // Last RUN edge is the one that drains rem to zero.
  always_comb begin
    nstate = state;
    unique case (state)
      ST_IDLE: if (start) nstate = ST_RUN;
      ST_RUN:
        if (rem <= RW'(STEP)) nstate = ST_DONE;
      ST_DONE:
        nstate = start ? ST_RUN : ST_IDLE;
      default: nstate = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result <= '0;
      cout   <= 1'b0;
      rem    <= '0;
      op_q   <= SH_LSL;
    end else if (accept) begin
      result <= operand_in;
      cout   <= ror_wrap ? operand_in[WIDTH-1]
                         : cin;
      rem    <= n;
      op_q   <= op;
    end else if (state == ST_RUN) begin
      result <= sv;
      cout   <= sc;
      rem    <= rem - RW'(k);
    end
  end

endmodule

// File: tb/tb_iterative_shifter_unit.sv
// Directed bench for iterative_shifter_unit, WIDTH=32 STEP=4.
// Hand-computed results, carries and latencies.
module tb_iterative_shifter_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] operand_in;
  logic [7:0]  amount;
  logic        cin;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        cout;

  int checks = 0;
  int errors = 0;

  iterative_shifter_unit #(
    .WIDTH (32),
    .STEP  (4),
    .AMT_W (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .operand_in (operand_in),
    .amount     (amount),
    .cin        (cin),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .cout       (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h",
               tag, got, exp);
    end
  endtask

  // Drive at negedge, return #1 after accept edge E0.
  task automatic launch(input logic [2:0]  o,
                        input logic [31:0] v,
                        input logic [7:0]  a,
                        input logic        c);
    @(negedge clk);
    op         = o;
    operand_in = v;
    amount     = a;
    cin        = c;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Called #1 after E0; returns #1 after the edge into DONE.
  task automatic finish_op(input string       tag,
                           input logic [31:0] er,
                           input logic        ec,
                           input int          lat,
                           input bit          poke);
    int cyc;
    int bcnt;
    cyc  = 0;
    bcnt = busy ? 1 : 0;
    chk({tag, "_busy0"}, {31'd0, busy}, 32'd1);
    while (!done && cyc < 100) begin
      if (poke && cyc == 1) begin
        @(negedge clk);
        start      = 1'b1;
        op         = 3'd1;
        operand_in = 32'h0;
        amount     = 8'd1;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc++;
      if (busy) bcnt++;
    end
    chk({tag, "_lat"}, cyc, lat);
    chk({tag, "_bcnt"}, bcnt, lat);
    chk({tag, "_res"}, result, er);
    chk({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
  endtask

  task automatic to_idle();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input string       tag,
                     input logic [2:0]  o,
                     input logic [31:0] v,
                     input logic [7:0]  a,
                     input logic        c,
                     input logic [31:0] er,
                     input logic        ec,
                     input int          lat);
    launch(o, v, a, c);
    finish_op(tag, er, ec, lat, 1'b0);
    to_idle();
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    op         = 3'd0;
    operand_in = 32'h0;
    amount     = 8'd0;
    cin        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_res", result, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    reset = 1'b0;
    to_idle();

    run("lsl3", 3'd0, 32'd35, 8'd3, 1'b0,
        32'd280, 1'b0, 1);
    run("lsr32", 3'd1, 32'h80000001, 8'd32,
        1'b0, 32'h0, 1'b1, 8);
    run("asr40", 3'd2, 32'h80000000, 8'd40,
        1'b0, 32'hFFFFFFFF, 1'b1, 9);
    run("ror36", 3'd3, 32'h000000F0, 8'd36,
        1'b1, 32'h0000000F, 1'b0, 1);
    run("ror32", 3'd3, 32'h80000000, 8'd32,
        1'b0, 32'h80000000, 1'b1, 1);
    run("rrx", 3'd4, 32'h00000003, 8'd0,
        1'b1, 32'h80000001, 1'b1, 1);
    run("lsl0", 3'd0, 32'h00001234, 8'd0,
        1'b1, 32'h00001234, 1'b1, 1);
    run("rsvd", 3'd6, 32'hA5A5A5A5, 8'd5,
        1'b0, 32'hA5A5A5A5, 1'b0, 1);
    run("lsl33", 3'd0, 32'hFFFFFFFF, 8'd33,
        1'b1, 32'h0, 1'b0, 9);
    run("lsr1", 3'd1, 32'h00000001, 8'd1,
        1'b0, 32'h0, 1'b1, 1);
    run("ror8", 3'd3, 32'h000000AB, 8'd8,
        1'b0, 32'hAB000000, 1'b1, 2);

    // start during RUN is ignored
    launch(3'd0, 32'h00001FFF, 8'd20, 1'b0);
    finish_op("poke", 32'hFFF00000, 1'b1, 5, 1'b1);

    // back-to-back accept in the DONE cycle
    launch(3'd1, 32'h00000100, 8'd4, 1'b0);
    chk("b2b_done", {31'd0, done}, 32'd0);
    finish_op("b2b", 32'h00000010, 1'b0, 1, 1'b0);
    to_idle();
    chk("idle_done", {31'd0, done}, 32'd0);

    // async reset mid-run
    launch(3'd0, 32'h00001FFF, 8'd20, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_busy", {31'd0, busy}, 32'd0);
    chk("ar_done", {31'd0, done}, 32'd0);
    chk("ar_res", result, 32'd0);
    chk("ar_cout", {31'd0, cout}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    to_idle();

    run("post", 3'd0, 32'h00000001, 8'd31,
        1'b0, 32'h80000000, 1'b0, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
